// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-port ALU arbiter: FSM encoding, the opcode
// the ALU does not implement, and the default datapath width.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] ILLEGAL_OP    = 3'b111;
    localparam int         DEFAULT_WIDTH = 16;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-facing bus of the ALU arbiter: two request channels and two
// response channels that share one result bus.
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [2:0]       req_op0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic [2:0]       req_op1;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_err;

    modport master (
        output req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_op0, req_a1, req_b1, req_op1, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins outright, a tie goes
// to the port that was not served last.
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req_valid;
        grant_id    = 1'b0;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: latch the winning operation,
// hold it on the ALU for SETTLE cycles, capture the result and hand it back.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             busy,
    output logic             grant_id
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;

    logic             win_valid;
    logic             win_id;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic [2:0]       win_op;
    logic             accept;

    rr_arb2 u_rr_arb2 (
        .req_valid   (bus.req_valid),
        .last_grant  (last_q),
        .grant_valid (win_valid),
        .grant_id    (win_id)
    );

    assign win_a  = win_id ? bus.req_a1  : bus.req_a0;
    assign win_b  = win_id ? bus.req_b1  : bus.req_b0;
    assign win_op = win_id ? bus.req_op1 : bus.req_op0;

    // Ready is withheld while rst is high so nothing handshakes during reset.
    assign accept        = (state_q == IDLE) && win_valid && !rst;
    assign bus.req_ready = accept ? (win_id ? 2'b10 : 2'b01) : 2'b00;

    assign bus.resp_valid = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_op         = alu_op_q;
    assign busy           = (state_q != IDLE);
    assign grant_id       = grant_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        grant_d     = grant_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    grant_d = win_id;
                    // Illegal ops never reach the ALU, so its inputs keep the last legal op.
                    if (win_op == ILLEGAL_OP) begin
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        state_d     = RESP;
                    end else begin
                        alu_a_d  = win_a;
                        alu_b_d  = win_b;
                        alu_op_d = win_op;
                        cnt_d    = CW'(SETTLE - 1);
                        state_d  = EXEC;
                    end
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    resp_data_d = alu_out;
                    resp_err_d  = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a SETTLE=1 instance for the main checks and
// a SETTLE=3 instance for the mid-execution reset case; the ALU is an adder.
module tb_alu_arbiter;

    logic clk;
    logic rst;
    logic rst3;

    alu_arbiter_if #(.WIDTH(16)) bus ();
    alu_arbiter_if #(.WIDTH(16)) bus3 ();

    logic [15:0] aluA, aluB, aluOut;
    logic [2:0]  aluOp;
    logic        busy, grantId;
    logic [15:0] aluA3, aluB3, aluOut3;
    logic [2:0]  aluOp3;
    logic        busy3, grantId3;

    assign aluOut  = aluA + aluB;
    assign aluOut3 = aluA3 + aluB3;

    alu_arbiter #(.WIDTH(16), .SETTLE(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .alu_a    (aluA),
        .alu_b    (aluB),
        .alu_op   (aluOp),
        .alu_out  (aluOut),
        .busy     (busy),
        .grant_id (grantId)
    );

    alu_arbiter #(.WIDTH(16), .SETTLE(3)) dut3 (
        .clk      (clk),
        .rst      (rst3),
        .bus      (bus3.slave),
        .alu_a    (aluA3),
        .alu_b    (aluB3),
        .alu_op   (aluOp3),
        .alu_out  (aluOut3),
        .busy     (busy3),
        .grant_id (grantId3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] expData;
        logic        expErr;
        int          expLat;
    } vec_t;

    vec_t vecs[6];
    int   nCompared  = 0;
    int   nMismatched = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Offers one request on a single port, returns edges from accept to resp_valid.
    task automatic applyStimulus(input logic port, input logic [15:0] a, input logic [15:0] b,
                                 input logic [2:0] op, output int lat);
        if (port) begin
            bus.req_a1 = a; bus.req_b1 = b; bus.req_op1 = op;
        end else begin
            bus.req_a0 = a; bus.req_b0 = b; bus.req_op0 = op;
        end
        bus.req_valid = port ? 2'b10 : 2'b01;
        #1;
        checkOutput("req_ready", {30'd0, bus.req_ready}, port ? 32'd2 : 32'd1);
        tick();
        bus.req_valid = 2'b00;
        lat = 0;
        while (bus.resp_valid == 2'b00 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic        lastGrant;
        logic        expWin;
        logic [2:0]  lastLegalOp;
        logic        sawResp;

        vecs[0] = '{1'b0, 16'd20,     16'd21,   3'b000, 16'd41,   1'b0, 1};
        vecs[1] = '{1'b1, 16'd100,    16'd200,  3'b001, 16'd300,  1'b0, 1};
        vecs[2] = '{1'b0, 16'hFFFF,   16'd1,    3'b010, 16'd0,    1'b0, 1};
        vecs[3] = '{1'b1, 16'd5,      16'd6,    3'b111, 16'd0,    1'b1, 0};
        vecs[4] = '{1'b0, 16'd1234,   16'd4321, 3'b110, 16'd5555, 1'b0, 1};
        vecs[5] = '{1'b1, 16'd3,      16'd4,    3'b011, 16'd7,    1'b0, 1};

        rst  = 1'b1;
        rst3 = 1'b1;
        bus.req_valid  = 2'b11;
        bus.resp_ready = 2'b11;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_op0 = '0;
        bus.req_a1 = '0; bus.req_b1 = '0; bus.req_op1 = '0;
        bus3.req_valid  = 2'b00;
        bus3.resp_ready = 2'b11;
        bus3.req_a0 = '0; bus3.req_b0 = '0; bus3.req_op0 = '0;
        bus3.req_a1 = '0; bus3.req_b1 = '0; bus3.req_op1 = '0;

        // Reset with both requests raised: nothing may be accepted.
        tick();
        checkOutput("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        checkOutput("rst_resp_valid", {30'd0, bus.resp_valid}, 32'd0);
        checkOutput("rst_alu_a", {16'd0, aluA}, 32'd0);
        checkOutput("rst_alu_b", {16'd0, aluB}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_grant_id", {31'd0, grantId}, 32'd0);
        checkOutput("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
        tick();
        checkOutput("rst_req_ready2", {30'd0, bus.req_ready}, 32'd0);
        bus.req_valid = 2'b00;
        rst = 1'b0;

        lastGrant   = 1'b1;
        lastLegalOp = 3'b000;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].op, lat);
            checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
            checkOutput($sformatf("v%0d_resp_valid", i), {30'd0, bus.resp_valid},
                        vecs[i].port ? 32'd2 : 32'd1);
            checkOutput($sformatf("v%0d_resp_data", i), {16'd0, bus.resp_data}, {16'd0, vecs[i].expData});
            checkOutput($sformatf("v%0d_resp_err", i), {31'd0, bus.resp_err}, {31'd0, vecs[i].expErr});
            checkOutput($sformatf("v%0d_grant_id", i), {31'd0, grantId}, {31'd0, vecs[i].port});
            if (vecs[i].expErr)
                checkOutput($sformatf("v%0d_alu_op_hold", i), {29'd0, aluOp}, {29'd0, lastLegalOp});
            else
                lastLegalOp = vecs[i].op;
            tick();
            checkOutput($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
            lastGrant = vecs[i].port;
        end

        // Both ports held valid: grants must alternate starting from the non-last port.
        bus.req_a0 = 16'd20; bus.req_b0 = 16'd21; bus.req_op0 = 3'b000;
        bus.req_a1 = 16'd51; bus.req_b1 = 16'd59; bus.req_op1 = 3'b000;
        bus.req_valid = 2'b11;
        expWin = ~lastGrant;
        checkOutput("cont_first_winner", {31'd0, expWin}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            lat = 0;
            while (bus.resp_valid == 2'b00 && lat < 12) begin
                tick();
                lat++;
            end
            checkOutput($sformatf("cont%0d_resp_valid", k), {30'd0, bus.resp_valid}, expWin ? 32'd2 : 32'd1);
            checkOutput($sformatf("cont%0d_resp_data", k), {16'd0, bus.resp_data}, expWin ? 32'd110 : 32'd41);
            tick();
            expWin = ~expWin;
        end
        bus.req_valid = 2'b00;

        // Backpressure on port 0 while port 1 waits; port 1's resp_ready must be ignored.
        bus.resp_ready = 2'b10;
        bus.req_a0 = 16'd59; bus.req_b0 = 16'd20; bus.req_op0 = 3'b000;
        bus.req_valid = 2'b01;
        #1;
        checkOutput("bp_req_ready", {30'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_a1 = 16'd1; bus.req_b1 = 16'd2; bus.req_op1 = 3'b000;
        bus.req_valid = 2'b10;
        lat = 0;
        while (bus.resp_valid == 2'b00 && lat < 12) begin
            tick();
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp%0d_resp_valid", k), {30'd0, bus.resp_valid}, 32'd1);
            checkOutput($sformatf("bp%0d_resp_data", k), {16'd0, bus.resp_data}, 32'd79);
            checkOutput($sformatf("bp%0d_req_ready", k), {30'd0, bus.req_ready}, 32'd0);
            tick();
        end
        bus.resp_ready = 2'b11;
        tick();
        checkOutput("bp_release_busy", {31'd0, busy}, 32'd0);
        checkOutput("bp_pending_ready", {30'd0, bus.req_ready}, 32'd2);
        tick();
        bus.req_valid = 2'b00;
        lat = 0;
        while (bus.resp_valid == 2'b00 && lat < 12) begin
            tick();
            lat++;
        end
        checkOutput("bp_pending_resp_valid", {30'd0, bus.resp_valid}, 32'd2);
        checkOutput("bp_pending_resp_data", {16'd0, bus.resp_data}, 32'd3);
        tick();

        // SETTLE=3 instance: reset during EXEC must drop the in-flight result.
        rst3 = 1'b0;
        bus3.req_a0 = 16'd10; bus3.req_b0 = 16'd20; bus3.req_op0 = 3'b000;
        bus3.req_valid = 2'b01;
        #1;
        checkOutput("s3_req_ready", {30'd0, bus3.req_ready}, 32'd1);
        tick();
        bus3.req_valid = 2'b00;
        tick();
        checkOutput("s3_busy_exec", {31'd0, busy3}, 32'd1);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        sawResp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus3.resp_valid != 2'b00) sawResp = 1'b1;
            tick();
        end
        checkOutput("s3_abort_no_resp", {31'd0, sawResp}, 32'd0);
        checkOutput("s3_abort_busy", {31'd0, busy3}, 32'd0);

        bus3.req_a0 = 16'd7; bus3.req_b0 = 16'd8;
        bus3.req_valid = 2'b01;
        #1;
        tick();
        bus3.req_valid = 2'b00;
        lat = 0;
        while (bus3.resp_valid == 2'b00 && lat < 12) begin
            tick();
            lat++;
        end
        checkOutput("s3_latency", lat, 32'd3);
        checkOutput("s3_resp_valid", {30'd0, bus3.resp_valid}, 32'd1);
        checkOutput("s3_resp_data", {16'd0, bus3.resp_data}, 32'd15);
        tick();
        checkOutput("s3_busy_after", {31'd0, busy3}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
